// File: rtl/prio_grant_arb8_pkg.sv
// prio_grant_arb8_pkg: shared constants, FSM state type and one-hot helper for the arbiter
package prio_grant_arb8_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/prio_grant_arb8_enc.sv
// pri_enc8: combinational 8-to-3 encoder, highest set bit wins; any_o flags a nonzero input
module pri_enc8
  import prio_grant_arb8_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N_REQ; i++) idx_o = req_i[i] ? IDX_W'(i) : idx_o;
  end
  assign any_o = |req_i;
endmodule

// File: rtl/prio_grant_arb8.sv
// prio_grant_arb8: 8-requester priority arbiter with hold timeout and one-cycle turnaround
// Ports: clk/rst (sync, active high), en gates new grants, req request lines, done owner release;
//        gnt one-hot grant, gnt_idx owner index, gnt_valid grant active, busy not idle,
//        timeout one-cycle pulse on MAX_HOLD revocation.
// Build option PRIO_GRANT_ARB8_RR_EN selects round-robin search instead of fixed priority.
module prio_grant_arb8
  import prio_grant_arb8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             busy,
  output logic             timeout
);
  localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] LIM = CW'(MAX_HOLD - 1);
  state_t state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, rot;
  logic [IDX_W-1:0] idx_q, idx_d, enc, w;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, tmo_q, tmo_d, any, rel, expire;
`ifdef PRIO_GRANT_ARB8_RR_EN
  logic [IDX_W-1:0] last_q, last_d;
  // rotating right by last_q puts last_q-1 at the top, so one fixed encoder yields the RR order
  assign rot = N_REQ'({req, req} >> last_q);
  assign w = enc + last_q;
`else
  assign rot = req;
  assign w = enc;
`endif
  pri_enc8 u_enc (.req_i(rot), .idx_o(enc), .any_o(any));
  assign rel = done || !req[idx_q];
  assign expire = (MAX_HOLD != 0) && (cnt_q == LIM);
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    idx_d = idx_q;
    valid_d = valid_q;
    cnt_d = cnt_q;
    tmo_d = 1'b0;
`ifdef PRIO_GRANT_ARB8_RR_EN
    last_d = last_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en && any) begin
          state_d = GRANT;
          gnt_d = onehot(w);
          idx_d = w;
          valid_d = 1'b1;
`ifdef PRIO_GRANT_ARB8_RR_EN
          last_d = w;
`endif
        end
      end
      GRANT: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (rel || expire) begin
          state_d = TURN;
          gnt_d = '0;
          valid_d = 1'b0;
          tmo_d = !rel;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      cnt_q <= '0;
      tmo_q <= 1'b0;
`ifdef PRIO_GRANT_ARB8_RR_EN
      last_q <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
`ifdef PRIO_GRANT_ARB8_RR_EN
      last_q <= last_d;
`endif
    end
  end
  assign gnt = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_valid = valid_q;
  assign busy = state_q != IDLE;
  assign timeout = tmo_q;
endmodule

// File: tb/tb_prio_grant_arb8.sv
// tb_prio_grant_arb8: directed self-checking bench for prio_grant_arb8 with MAX_HOLD=4
module tb_prio_grant_arb8;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, done = 1'b0;
  logic [7:0] req = '0, gnt;
  logic [2:0] gnt_idx;
  logic gnt_valid, busy, timeout;
  int total = 0, bad = 0;
  prio_grant_arb8 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done), .gnt(gnt),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v,
                         input logic b, input logic t);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    if (v) chk({tag, ".idx"}, 32'(gnt_idx), 32'(i));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(v));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".tmo"}, 32'(timeout), 32'(t));
  endtask
  initial begin
    tick();
    tick();
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.idx", 32'(gnt_idx), 32'd0);
    rst = 1'b0;
    en = 1'b1;
    req = 8'h10;
    tick();
    chk_out("g10", 8'h10, 3'd4, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_out("rst_mid", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    req = 8'h00;
    tick();
    chk_out("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    req = 8'b0010_0101;
    tick();
    chk_out("fix5", 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
    done = 1'b1;
    req = 8'h05;
    tick();
    chk_out("turn1", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    done = 1'b0;
    tick();
    chk_out("idle1", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("fix2", 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);
    req = 8'h85;
    tick();
    chk_out("nopre1", 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("nopre2", 8'h04, 3'd2, 1'b1, 1'b1, 1'b0);
    done = 1'b1;
    req = 8'h80;
    tick();
    chk_out("turn2", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    done = 1'b0;
    tick();
    tick();
    chk_out("g80", 8'h80, 3'd7, 1'b1, 1'b1, 1'b0);
    done = 1'b1;
    req = 8'h00;
    tick();
    done = 1'b0;
    tick();
    chk_out("idle2", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    req = 8'h01;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("hold%0d", k), 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
    end
    tick();
    chk_out("tmo_pulse", 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("tmo_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("regrant", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    chk_out("done_at_lim", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    done = 1'b0;
    req = 8'h00;
    tick();
    en = 1'b0;
    req = 8'hFF;
    tick();
    tick();
    chk_out("en_off", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    req = 8'h08;
    tick();
    chk_out("g08", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    chk_out("en_fall", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_out("withdraw", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("wd_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
